load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the memory block. Accepts one load/store request at a time.
//  Presents word-aligned accesses to memory. Sub-word stores use read-modify-write, because the RAM
//  has no byte enables. Load data is extracted and sign/zero-extended. Misaligned accesses are flagged.
// PARAMETERS
//  WIDTH          32  data/address width in bits; only 32 is supported
//  MISALIGN_TRAP  1   1: misaligned access -> resp_err, no memory access; 0: low addr bits forced to 0, no error
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-low (0 = reset)
//  req_valid    in   1      request present
//  req_ready    out  1      unit can accept (high only in IDLE)
//  req_we       in   1      0 = load, 1 = store
//  req_addr     in   WIDTH  byte address
//  req_wdata    in   WIDTH  store data, right-aligned
//  req_funct3   in   funct3_t  RV32 size/sign code
//  resp_valid   out  1      one-cycle completion pulse; no backpressure
//  resp_rdata   out  WIDTH  extended load data; 0 for stores and errors
//  resp_err     out  1      misaligned or illegal funct3; valid with resp_valid
//  mem_addr     out  WIDTH  word-aligned byte address ([1:0] = 0)
//  mem_wren     out  1      memory write enable
//  mem_wr_data  out  WIDTH  full-word write data
//  mem_funct3   out  funct3_t  tied to WORD
//  mem_rd_data  in   WIDTH  memory read data; valid the cycle after the address is presented
// BEHAVIOUR
//  States: IDLE, RD, WAIT, WR, RESP. req_ready = (state == IDLE).
//  Accept in cycle N (IDLE && req_valid): capture we/addr/wdata/funct3.
//  Legality:
//   - loads: funct3 must be LB, LH, LW, LBU or LHU
//   - stores: funct3 must be SB, SH or SW
//   - LH/LHU/SH need addr[0] = 0; LW/SW need addr[1:0] = 0
//   - illegal funct3 always errors; misalignment errors only when MISALIGN_TRAP = 1
//  Error: IDLE -> RESP. No memory cycle; resp_err = 1, resp_rdata = 0.
//  Load: N+1 RD (mem_addr driven, mem_wren = 0); N+2 WAIT (extract mem_rd_data into resp reg); N+3 RESP.
//   - byte lane = addr[1:0]; half lane = addr[1]
//   - LB/LH sign-extend; LBU/LHU zero-extend
//  SW: IDLE -> WR at N+1 (mem_wren = 1, mem_wr_data = wdata); RESP at N+2.
//  SB/SH (read-modify-write):
//   - N+1 RD; N+2 WAIT captures merged word: lane(s) replaced by wdata[7:0]/[15:0], other bytes kept
//   - N+3 WR writes the merged word; N+4 RESP
//  RESP lasts exactly one cycle, then IDLE. The next accept happens no earlier than the cycle after RESP.
//  One request in flight; req_valid while busy is ignored (req_ready = 0).
//  mem_* outputs are decoded from the state and captured registers:
//   - mem_wren is high only in WR
//   - mem_addr holds the captured address & ~3 in RD/WAIT/WR, 0 in IDLE
//   - address 0xFFFC (outport) needs no special handling
//  Reset (rst = 0, any time):
//   - state -> IDLE; all captured registers, resp_rdata and resp_err -> 0
//   - resp_valid = 0, mem_wren = 0, req_ready = 1 after release
//   - a reset during WR aborts the write immediately; memory contents are then unspecified for that word
// STRUCTURE
//  LOAD_STORE_FNS package gains:
//   - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW
//   - lsu_state_t enum (IDLE, RD, WAIT, WR, RESP)
//   - function is_legal(we, funct3, addr[1:0], trap)
//  Sub-module lsu_align (combinational): extract/extend on load, lane merge on sub-word store.
//  Inputs: word, addr[1:0], funct3, wdata. Outputs: load_data, merged_word.
// TESTING
//  LW 0x100, mem word 0xDEADBEEF -> resp_valid at N+3, rdata 0xDEADBEEF, err 0
//  LB 0x103 / LBU 0x103 on word 0x80112233 -> rdata 0xFFFFFF80 / 0x00000080
//  SB 0x101, wdata 0xAB over word 0x11223344 -> WR at N+3 writes 0x1122AB44; resp at N+4
//  SH 0x102, wdata 0xCAFE over 0x11223344 -> 0xCAFE3344; then LHU 0x102 -> 0x0000CAFE
//  LW 0x102 (trap = 1) -> resp_err = 1 at N+1, mem_wren never high; funct3 = 3'b011 load -> err
//  rst low during WR of SB -> mem_wren drops same cycle, req_ready = 1 after release; back-to-back SW accepted

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: RV32 size codes, FSM states and
// the request legality check.
package load_store_unit_pkg;

   typedef logic [2:0] funct3_t;

   localparam funct3_t LB   = 3'b000;
   localparam funct3_t LH   = 3'b001;
   localparam funct3_t LW   = 3'b010;
   localparam funct3_t LBU  = 3'b100;
   localparam funct3_t LHU  = 3'b101;
   localparam funct3_t SB   = 3'b000;
   localparam funct3_t SH   = 3'b001;
   localparam funct3_t SW   = 3'b010;
   localparam funct3_t WORD = LW;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} lsu_state_t;

   // funct3[1:0] encodes the access size (00 byte, 01 half, 10 word) for loads and stores alike.
   function automatic logic is_legal(input logic we, input funct3_t funct3,
                                     input logic [1:0] addr_lo, input logic trap);
      logic size_ok;
      logic align_ok;
      if (we)
         size_ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
      else
         size_ok = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                   (funct3 == LBU) || (funct3 == LHU);
      case (funct3[1:0])
         2'b01:   align_ok = ~addr_lo[0];
         2'b10:   align_ok = (addr_lo == 2'b00);
         default: align_ok = 1'b1;
      endcase
      return size_ok && (align_ok || !trap);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and the
// byte/half merge used by read-modify-write stores.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  funct3_t     funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
         LH:      load_data = {{16{half_sel[15]}}, half_sel};
         LBU:     load_data = {24'd0, byte_sel};
         LHU:     load_data = {16'd0, half_sel};
         default: load_data = word;
      endcase
   end

   // Each byte lane is either replaced by the matching store byte or kept from the read word.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = (funct3[1:0] == 2'b00) ? (addr_lo == 2'(gi)) :
                        (funct3[1:0] == 2'b01) ? (addr_lo[1] == 1'(gi / 2)) : 1'b1;
      assign lane_src = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                        (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] : wdata[8*gi +: 8];
      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : word[8*gi +: 8];
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word-aligned memory port, read-modify-write for
// sub-word stores, extended load data and misalignment/illegal-size reporting.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter bit MISALIGN_TRAP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  funct3_t          req_funct3,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wren,
   output logic [WIDTH-1:0] mem_wr_data,
   output funct3_t          mem_funct3,
   input  logic [WIDTH-1:0] mem_rd_data
);

   lsu_state_t       state_q, state_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   funct3_t          funct3_q, funct3_d;
   logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic             resp_err_q, resp_err_d;

   logic             accept;
   logic             req_legal;
   logic [WIDTH-1:0] req_addr_eff;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] merged_word;

   assign accept    = (state_q == IDLE) && req_valid;
   assign req_legal = is_legal(req_we, req_funct3, req_addr[1:0], MISALIGN_TRAP);

   // Without trapping, misaligned halves/words are silently aligned down.
   always_comb begin
      req_addr_eff = req_addr;
      if (!MISALIGN_TRAP) begin
         if (req_funct3[1:0] == 2'b01)
            req_addr_eff[0] = 1'b0;
         else if (req_funct3[1:0] == 2'b10)
            req_addr_eff[1:0] = 2'b00;
      end
   end

   lsu_align u_align (
      .word        (mem_rd_data),
      .addr_lo     (addr_q[1:0]),
      .funct3      (funct3_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (!req_legal)
                  state_d = RESP;
               else if (req_we && (req_funct3 == SW))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:      state_d = WAIT;
         WAIT:    state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sub-word stores park the merged word in wdata_q so WR writes it unchanged.
   always_comb begin
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      if (accept) begin
         we_d         = req_we;
         addr_d       = req_addr_eff;
         wdata_d      = req_wdata;
         funct3_d     = req_funct3;
         resp_rdata_d = '0;
         resp_err_d   = ~req_legal;
      end else if (state_q == WAIT) begin
         if (we_q)
            wdata_d = merged_word;
         else
            resp_rdata_d = load_data;
      end
   end

   always_comb begin
      req_ready   = (state_q == IDLE);
      resp_valid  = (state_q == RESP);
      mem_wren    = (state_q == WR);
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_funct3  = WORD;
      if ((state_q == RD) || (state_q == WAIT) || (state_q == WR))
         mem_addr = {addr_q[WIDTH-1:2], 2'b00};
      if (state_q == WR)
         mem_wr_data = wdata_q;
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: behavioural word RAM, expected responses queued
// at request time and compared (data, error, latency) when resp_valid pulses.
module tb_load_store_unit;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wr_data;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rd_data = '0;

   logic [31:0] mem [0:255];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          wr_count = 0;
   int          last_wr_cyc = 0;
   logic [31:0] last_wr_data = '0;
   logic [31:0] last_wr_addr = '0;
   int          last_acc = 0;
   exp_t        sb_q[$];

   load_store_unit #(.WIDTH(32), .MISALIGN_TRAP(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_funct3  (req_funct3),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_addr    (mem_addr),
      .mem_wren    (mem_wren),
      .mem_wr_data (mem_wr_data),
      .mem_funct3  (mem_funct3),
      .mem_rd_data (mem_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_we)
         mem[pl_idx] <= pl_val;
      else if (mem_wren)
         mem[mem_addr[9:2]] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr[9:2]];
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (mem_wren) begin
            wr_count++;
            last_wr_cyc  = cyc;
            last_wr_data = mem_wr_data;
            last_wr_addr = mem_addr;
         end
         if (resp_valid) begin
            if (sb_q.size() == 0) begin
               check_value("spurious_resp", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("resp cyc=%0d rdata=%h err=%0b lat=%0d", cyc, resp_rdata, resp_err, cyc - e.acc);
               check_value("resp_rdata", resp_rdata, e.rdata);
               check_value("resp_err", 32'(resp_err), 32'(e.err));
               check_value("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
         end
      end
   end

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      @(negedge clk);
      pl_we  = 1'b1;
      pl_idx = addr[9:2];
      pl_val = val;
      @(negedge clk);
      pl_we  = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
      int n;
      exp_t e;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready)
         check_value("ready_timeout", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = cyc;
      e.lat   = exp_lat;
      last_acc = cyc;
      sb_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || !req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check_value("resp_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   initial begin
      int n;
      int wr_before;
      int acc_first;
      repeat (2) @(negedge clk);
      check_value("rst_req_ready", 32'(req_ready), 32'd1);
      check_value("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_value("rst_mem_wren", 32'(mem_wren), 32'd0);
      check_value("rst_mem_addr", mem_addr, 32'd0);
      check_value("rst_resp_rdata", resp_rdata, 32'd0);
      check_value("rst_resp_err", 32'(resp_err), 32'd0);
      check_value("mem_funct3", 32'(mem_funct3), 32'(F_W));
      rst = 1'b1;

      preload(32'h100, 32'hDEADBEEF);
      do_req(1'b0, 32'h100, 32'h0, F_W, 32'hDEADBEEF, 1'b0, 3);
      wait_idle();

      preload(32'h100, 32'h80112233);
      do_req(1'b0, 32'h103, 32'h0, F_B, 32'hFFFFFF80, 1'b0, 3);
      wait_idle();
      do_req(1'b0, 32'h103, 32'h0, F_BU, 32'h00000080, 1'b0, 3);
      wait_idle();
      do_req(1'b0, 32'h100, 32'h0, F_H, 32'h00002233, 1'b0, 3);
      wait_idle();

      preload(32'h100, 32'h11223344);
      do_req(1'b1, 32'h101, 32'h000000AB, F_B, 32'h0, 1'b0, 4);
      wait_idle();
      check_value("sb_wr_cycle", 32'(last_wr_cyc - last_acc), 32'd3);
      check_value("sb_wr_data", last_wr_data, 32'h1122AB44);
      check_value("sb_wr_addr", last_wr_addr, 32'h100);
      check_value("sb_mem", mem[8'h40], 32'h1122AB44);

      preload(32'h100, 32'h11223344);
      do_req(1'b1, 32'h102, 32'h0000CAFE, F_H, 32'h0, 1'b0, 4);
      wait_idle();
      check_value("sh_mem", mem[8'h40], 32'hCAFE3344);
      do_req(1'b0, 32'h102, 32'h0, F_HU, 32'h0000CAFE, 1'b0, 3);
      wait_idle();
      do_req(1'b0, 32'h102, 32'h0, F_H, 32'hFFFFCAFE, 1'b0, 3);
      wait_idle();

      wr_before = wr_count;
      do_req(1'b0, 32'h102, 32'h0, F_W, 32'h0, 1'b1, 1);
      wait_idle();
      do_req(1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1, 1);
      wait_idle();
      do_req(1'b1, 32'h101, 32'h12345678, F_H, 32'h0, 1'b1, 1);
      wait_idle();
      do_req(1'b1, 32'h100, 32'h12345678, F_BU, 32'h0, 1'b1, 1);
      wait_idle();
      check_value("err_no_write", 32'(wr_count), 32'(wr_before));
      check_value("err_mem_intact", mem[8'h40], 32'hCAFE3344);

      preload(32'h120, 32'h11223344);
      do_req(1'b1, 32'h120, 32'h000000AB, F_B, 32'h0, 1'b0, 4);
      n = 0;
      while (!mem_wren && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_value("rmw_reached_wr", 32'(mem_wren), 32'd1);
      rst = 1'b0;
      #1;
      check_value("rst_wr_abort", 32'(mem_wren), 32'd0);
      check_value("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_value("post_rst_ready", 32'(req_ready), 32'd1);
      check_value("post_rst_rdata", resp_rdata, 32'd0);

      do_req(1'b1, 32'h110, 32'hA5A5A5A5, F_W, 32'h0, 1'b0, 2);
      acc_first = last_acc;
      do_req(1'b1, 32'h114, 32'h5A5A5A5A, F_W, 32'h0, 1'b0, 2);
      check_value("b2b_accept_gap", 32'(last_acc - acc_first), 32'd3);
      wait_idle();
      check_value("sw_mem0", mem[8'h44], 32'hA5A5A5A5);
      check_value("sw_mem1", mem[8'h45], 32'h5A5A5A5A);
      do_req(1'b0, 32'h114, 32'h0, F_W, 32'h5A5A5A5A, 1'b0, 3);
      wait_idle();

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
